// File: rtl/spi32_slave.sv
// spi32_slave: mode-0 SPI responder, MSB first, with back-to-back word support.
// Ports: clk_in/reset_n, SCK_C/CS_S/MOSI_DQ0/MISO_DQ1 (SPI), tx_data/tx_ack,
//        rx_data/rx_valid, busy, frame_err, word_count.
module spi32_slave #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             SCK_C,
  input  logic             CS_S,
  input  logic             MOSI_DQ0,
  input  logic [WIDTH-1:0] tx_data,
  output logic             MISO_DQ1,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_ack,
  output logic             busy,
  output logic             frame_err,
  output logic [7:0]       word_count
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT
  } state_t;

  state_t r_state;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_cs_d;
  logic [SYNC_STAGES:0]   r_vld;

  logic [WIDTH-2:0] r_tx_shift;
  logic [WIDTH-2:0] r_rx_shift;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_sampled;
  logic             r_reload;

  logic             w_sck;
  logic             w_cs;
  logic             w_mosi;
  logic             w_real;
  logic             w_sck_rise;
  logic             w_sck_fall;
  logic             w_cs_fall;
  logic             w_cs_rise;
  logic [WIDTH-1:0] w_rx_next;

  assign w_sck  = r_sck_sync[SYNC_STAGES-1];
  assign w_cs   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  // The delayed copies only hold genuine pin samples once the preset
  // values have drained; until then no edge is reported, so a CS that
  // is already low when reset releases never looks like a frame start.
  assign w_real = r_vld[SYNC_STAGES];

  assign w_sck_rise = w_real & w_sck & ~r_sck_d;
  assign w_sck_fall = w_real & ~w_sck & r_sck_d;
  assign w_cs_fall  = w_real & ~w_cs & r_cs_d;
  assign w_cs_rise  = w_real & w_cs & ~r_cs_d;

  assign w_rx_next = {r_rx_shift, w_mosi};

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '1;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
      r_vld       <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SCK_C};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS_S};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI_DQ0};
      r_sck_d     <= w_sck;
      r_cs_d      <= w_cs;
      r_vld       <= {r_vld[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_bit_cnt  <= '0;
      r_sampled  <= 1'b0;
      r_reload   <= 1'b0;
      MISO_DQ1   <= 1'b1;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      tx_ack     <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      word_count <= '0;
    end else begin
      rx_valid  <= 1'b0;
      tx_ack    <= 1'b0;
      frame_err <= 1'b0;
      if (w_cs_rise) begin
        // CS wins over a coincident SCK rise; partial word is dropped.
        r_state   <= S_IDLE;
        MISO_DQ1  <= 1'b1;
        busy      <= 1'b0;
        frame_err <= (r_bit_cnt != '0);
        r_bit_cnt <= '0;
        r_sampled <= 1'b0;
        r_reload  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            MISO_DQ1 <= 1'b1;
            busy     <= 1'b0;
            if (w_cs_fall) begin
              r_state <= S_LOAD;
            end
          end
          S_LOAD: begin
            r_tx_shift <= tx_data[WIDTH-2:0];
            MISO_DQ1   <= tx_data[WIDTH-1];
            tx_ack     <= 1'b1;
            r_bit_cnt  <= '0;
            r_sampled  <= 1'b0;
            r_reload   <= 1'b0;
            busy       <= 1'b1;
            word_count <= '0;
            r_state    <= S_SHIFT;
          end
          S_SHIFT: begin
            if (w_sck_rise) begin
              r_rx_shift <= w_rx_next[WIDTH-2:0];
              r_sampled  <= 1'b1;
              if (r_bit_cnt == CW'(WIDTH - 1)) begin
                rx_data   <= w_rx_next;
                rx_valid  <= 1'b1;
                r_bit_cnt <= '0;
                r_reload  <= 1'b1;
                if (word_count != 8'hFF) begin
                  word_count <= word_count + 8'd1;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + CW'(1);
              end
            end else if (w_sck_fall && r_sampled) begin
              if (r_reload) begin
                // Next word is taken on the fall after the last bit,
                // so its MSB is on MISO before the next rise.
                r_tx_shift <= tx_data[WIDTH-2:0];
                MISO_DQ1   <= tx_data[WIDTH-1];
                tx_ack     <= 1'b1;
                r_reload   <= 1'b0;
                r_sampled  <= 1'b0;
              end else begin
                MISO_DQ1   <= r_tx_shift[WIDTH-2];
                r_tx_shift <= {r_tx_shift[WIDTH-3:0], 1'b0};
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
